// File: rtl/nv_nvdla_cdp_rdma_dp_tx_pkg.sv
// Shared CDP RDMA-to-datapath definitions: payload bit positions, FSM states
// and the payload packing helper.
package nv_nvdla_cdp_rdma_dp_tx_pkg;

  localparam int PD_W          = 87;
  localparam int DAT_W         = 64;
  localparam int LAST_STRIPE_W = 72;
  localparam int LAST_STRIPE_H = 73;
  localparam int LAST_SPLIT    = 75;
  localparam int LAST_W        = 76;
  localparam int LAST_H        = 77;
  localparam int LAST_C        = 78;
  localparam int LANE_LSB      = 79;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // The stripe/split flags only ever mark the final beat of the whole cube.
  function automatic logic [PD_W-1:0] build_pd(
    input logic [DAT_W-1:0] dat,
    input logic             last_w,
    input logic             last_h,
    input logic             last_c,
    input logic [1:0]       lanes_m1
  );
    logic [PD_W-1:0] pd;
    pd                     = {PD_W{1'b0}};
    pd[DAT_W-1:0]          = dat;
    pd[LAST_STRIPE_W]      = last_c;
    pd[LAST_STRIPE_H]      = last_c;
    pd[LAST_SPLIT]         = last_c;
    pd[LAST_W]             = last_w;
    pd[LAST_H]             = last_h;
    pd[LAST_C]             = last_c;
    pd[LANE_LSB +: 2]      = lanes_m1;
    return pd;
  endfunction

endpackage

// File: rtl/nv_nvdla_cdp_rdma_dp_tx_pos_cnt.sv
// W/H/channel-group position counter nest; w is fastest. Last flags are
// combinational from the current position and the latched cube size.
module nv_nvdla_cdp_rdma_pos_cnt #(
  parameter int CNT_W = 13
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic [CNT_W-1:0] i_width,
  input  logic [CNT_W-1:0] i_height,
  input  logic [CNT_W-1:0] i_cgrp_max,
  output logic             o_last_w,
  output logic             o_last_h,
  output logic             o_last_c,
  output logic             o_last_cg
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_w_cnt;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_c_cnt;

  assign o_last_cg = (r_c_cnt == i_cgrp_max);
  assign o_last_w  = (r_w_cnt == i_width);
  assign o_last_h  = o_last_w & (r_h_cnt == i_height);
  assign o_last_c  = o_last_h & o_last_cg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_w_cnt <= CNT_ZERO;
      r_h_cnt <= CNT_ZERO;
      r_c_cnt <= CNT_ZERO;
    end else if (i_adv) begin
      if (o_last_w) begin
        r_w_cnt <= CNT_ZERO;
        if (o_last_h) begin
          r_h_cnt <= CNT_ZERO;
          r_c_cnt <= o_last_c ? CNT_ZERO : (r_c_cnt + CNT_ONE);
        end else begin
          r_h_cnt <= r_h_cnt + CNT_ONE;
        end
      end else begin
        r_w_cnt <= r_w_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_cdp_rdma_dp_tx.sv
// CDP RDMA egress: tags raw read-return beats with cube position info and
// hands them to the datapath through a single output pipeline register.
module nv_nvdla_cdp_rdma_dp_tx
  import nv_nvdla_cdp_rdma_dp_tx_pkg::*;
#(
  parameter int CNT_W   = 13,
  parameter int STALL_W = 32
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  input  logic               reg2dp_op_en,
  input  logic [CNT_W-1:0]   reg2dp_width,
  input  logic [CNT_W-1:0]   reg2dp_height,
  input  logic [CNT_W-1:0]   reg2dp_channel,
  input  logic               dat_vld,
  input  logic [DAT_W-1:0]   dat_pd,
  output logic               dat_rdy,
  output logic               cdp_rdma2dp_valid,
  input  logic               cdp_rdma2dp_ready,
  output logic [PD_W-1:0]    cdp_rdma2dp_pd,
  output logic               rdma_done,
  output logic [STALL_W-1:0] dp2reg_stall_cnt
);

  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  state_e             r_state;
  logic               r_op_en_d1;
  logic [CNT_W-1:0]   r_width;
  logic [CNT_W-1:0]   r_height;
  logic [CNT_W-1:0]   r_cgrp_max;
  logic [1:0]         r_lane_last;
  logic               r_valid;
  logic [PD_W-1:0]    r_pd;
  logic               r_done;
  logic [STALL_W-1:0] r_stall;

  logic               w_start;
  logic               w_accept;
  logic               w_out_fire;
  logic               w_last_w;
  logic               w_last_h;
  logic               w_last_c;
  logic               w_last_cg;
  logic [1:0]         w_lanes_m1;

  // op_en_d1 follows the level in every state, so edges seen outside IDLE are consumed.
  assign w_start    = (r_state == ST_IDLE) & reg2dp_op_en & ~r_op_en_d1;
  assign dat_rdy    = (r_state == ST_RUN) & (~r_valid | cdp_rdma2dp_ready);
  assign w_accept   = dat_vld & dat_rdy;
  assign w_out_fire = r_valid & cdp_rdma2dp_ready;
  assign w_lanes_m1 = w_last_cg ? r_lane_last : 2'd3;

  assign cdp_rdma2dp_valid = r_valid;
  assign cdp_rdma2dp_pd    = r_pd;
  assign rdma_done         = r_done;
  assign dp2reg_stall_cnt  = r_stall;

  nv_nvdla_cdp_rdma_pos_cnt #(
    .CNT_W (CNT_W)
  ) u_pos_cnt (
    .i_clk      (nvdla_core_clk),
    .i_rst      (nvdla_core_rst),
    .i_clr      (w_start),
    .i_adv      (w_accept),
    .i_width    (r_width),
    .i_height   (r_height),
    .i_cgrp_max (r_cgrp_max),
    .o_last_w   (w_last_w),
    .o_last_h   (w_last_h),
    .o_last_c   (w_last_c),
    .o_last_cg  (w_last_cg)
  );

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state    <= ST_IDLE;
      r_op_en_d1 <= 1'b0;
    end else begin
      r_op_en_d1 <= reg2dp_op_en;
      case (r_state)
        ST_IDLE:  if (w_start)               r_state <= ST_RUN;
        ST_RUN:   if (w_accept && w_last_c)  r_state <= ST_DRAIN;
        ST_DRAIN: if (w_out_fire)            r_state <= ST_IDLE;
        default:                             r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_width     <= {CNT_W{1'b0}};
      r_height    <= {CNT_W{1'b0}};
      r_cgrp_max  <= {CNT_W{1'b0}};
      r_lane_last <= 2'd0;
    end else if (w_start) begin
      r_width     <= reg2dp_width;
      r_height    <= reg2dp_height;
      r_cgrp_max  <= reg2dp_channel >> 2;
      r_lane_last <= reg2dp_channel[1:0];
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_valid <= 1'b0;
      r_pd    <= {PD_W{1'b0}};
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pd    <= build_pd(dat_pd, w_last_w, w_last_h, w_last_c, w_lanes_m1);
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  // Done lines up with the DRAIN -> IDLE transition; stall count holds between layers.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_done  <= 1'b0;
      r_stall <= {STALL_W{1'b0}};
    end else begin
      r_done <= (r_state == ST_DRAIN) & w_out_fire;
      if (w_start) begin
        r_stall <= {STALL_W{1'b0}};
      end else if (r_valid && !cdp_rdma2dp_ready && (r_stall != STALL_MAX)) begin
        r_stall <= r_stall + STALL_ONE;
      end
    end
  end

endmodule

// File: tb/tb_nv_nvdla_cdp_rdma_dp_tx.sv
// Self-checking bench for nv_nvdla_cdp_rdma_dp_tx: random beat data and ready
// against a nested-loop reference of the cube walk.
module tb_nv_nvdla_cdp_rdma_dp_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_en;
  logic [12:0] width_r, height_r, channel_r;
  logic        dat_vld;
  logic [63:0] dat_pd;
  logic        dat_rdy;
  logic        out_valid;
  logic        out_ready;
  logic [86:0] out_pd;
  logic        done;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nv_nvdla_cdp_rdma_dp_tx #(.CNT_W(13), .STALL_W(32)) dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .reg2dp_op_en      (op_en),
    .reg2dp_width      (width_r),
    .reg2dp_height     (height_r),
    .reg2dp_channel    (channel_r),
    .dat_vld           (dat_vld),
    .dat_pd            (dat_pd),
    .dat_rdy           (dat_rdy),
    .cdp_rdma2dp_valid (out_valid),
    .cdp_rdma2dp_ready (out_ready),
    .cdp_rdma2dp_pd    (out_pd),
    .rdma_done         (done),
    .dp2reg_stall_cnt  (stall_cnt)
  );

  // Reference: expected payload for each beat, from the cube walk rules.
  function automatic logic [86:0] ref_pd(input logic [63:0] d, input int w, input int h, input int cg,
                                         input int wr, input int hr, input int cr);
    logic [86:0] p;
    bit lw, lh, lc;
    int cgmax;
    cgmax = cr / 4;
    lw = (w == wr);
    lh = lw && (h == hr);
    lc = lh && (cg == cgmax);
    p = 87'd0;
    p[63:0] = d;
    p[72] = lc; p[73] = lc; p[75] = lc;
    p[76] = lw; p[77] = lh; p[78] = lc;
    p[80:79] = (cg == cgmax) ? 2'(cr % 4) : 2'd3;
    return p;
  endfunction

  // Runs one layer; abort_after>0 stops driving once that many beats were accepted.
  task automatic run_layer(input string name, input int wr, input int hr, input int cr,
                           input int rdy_pct, input int hold_from, input int abort_after);
    logic [63:0] dq[$];
    logic [86:0] eq[$];
    logic [86:0] pd_prev;
    int nbeats, src, outn, stall_exp;
    bit finished, last_fire, stalled_prev;
    nbeats = (wr + 1) * (hr + 1) * (cr / 4 + 1);
    for (int i = 0; i < nbeats; i++) dq.push_back({$urandom(), $urandom()});
    begin
      int k;
      k = 0;
      for (int cg = 0; cg <= cr / 4; cg++)
        for (int h = 0; h <= hr; h++)
          for (int w = 0; w <= wr; w++) begin
            eq.push_back(ref_pd(dq[k], w, h, cg, wr, hr, cr));
            k++;
          end
    end
    width_r = 13'(wr); height_r = 13'(hr); channel_r = 13'(cr);
    src = 0; outn = 0; stall_exp = 0;
    finished = 1'b0; last_fire = 1'b0; stalled_prev = 1'b0; pd_prev = 87'd0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      op_en = (cyc == 0) || (hold_from >= 0 && cyc >= hold_from);
      out_ready = ($urandom_range(99) < rdy_pct);
      dat_vld = (src < nbeats);
      dat_pd = dat_vld ? dq[src] : 64'd0;
      #1;
      checks++;
      if (done !== last_fire) begin
        errors++;
        $display("FAIL %s done cyc=%0d: got %b want %b", name, cyc, done, last_fire);
      end
      if (done) finished = 1'b1;
      if (stalled_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_pd !== pd_prev) begin
          errors++;
          $display("FAIL %s hold cyc=%0d: valid=%b pd=%h want pd=%h", name, cyc, out_valid, out_pd, pd_prev);
        end
      end
      if (dat_vld && dat_rdy) src++;
      last_fire = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (outn >= nbeats) begin
          errors++;
          $display("FAIL %s extra beat: got %h want none", name, out_pd);
        end else begin
          if (out_pd !== eq[outn]) begin
            errors++;
            $display("FAIL %s beat%0d: got %h want %h", name, outn, out_pd, eq[outn]);
          end
          if (outn == nbeats - 1) last_fire = 1'b1;
        end
        outn++;
      end
      stalled_prev = out_valid && !out_ready;
      pd_prev = out_pd;
      if (stalled_prev) stall_exp++;
      if (abort_after > 0 && src >= abort_after) break;
    end
    if (abort_after == 0) begin
      checks++;
      if (!finished || outn != nbeats) begin
        errors++;
        $display("FAIL %s completion: got beats=%0d done=%b want beats=%0d done=1", name, outn, finished, nbeats);
      end
      @(negedge clk);
      dat_vld = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || stall_cnt !== 32'(stall_exp)) begin
        errors++;
        $display("FAIL %s stall/after: got done=%b stall=%0d want done=0 stall=%0d", name, done, stall_cnt, stall_exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op_en = 1'b0; dat_vld = 1'b1; dat_pd = 64'hDEAD_BEEF_0123_4567;
    out_ready = 1'b1; width_r = 13'd0; height_r = 13'd0; channel_r = 13'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (dat_rdy !== 1'b0 || out_valid !== 1'b0 || out_pd !== 87'd0 || done !== 1'b0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b pd=%h done=%b stall=%0d want all 0", dat_rdy, out_valid, out_pd, done, stall_cnt);
    end
    dat_vld = 1'b0;
  endtask

  task automatic test_min_cube();
    run_layer("min_1x1x1", 0, 0, 0, 100, -1, 0);
  endtask

  task automatic test_basic();
    run_layer("w3h2c8", 2, 1, 7, 100, -1, 0);
  endtask

  task automatic test_c5();
    run_layer("c5", 2, 1, 4, 100, -1, 0);
  endtask

  task automatic test_random_ready();
    run_layer("rand_rdy30", 3, 2, 6, 30, -1, 0);
    run_layer("rand_rdy30b", 1, 3, 9, 30, -1, 0);
  endtask

  task automatic test_op_en_ignored();
    // op_en rises again mid-layer and stays high: no new layer may start.
    run_layer("op_en_mid", 2, 1, 7, 100, 5, 0);
    dat_vld = 1'b1;
    dat_pd = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (dat_rdy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL op_en_level idle%0d: got rdy=%b vld=%b want 0 0", i, dat_rdy, out_valid);
      end
    end
    dat_vld = 1'b0;
    op_en = 1'b0;
    @(negedge clk);
    run_layer("op_en_next", 1, 1, 3, 100, -1, 0);
  endtask

  task automatic test_reset_mid_layer();
    run_layer("rst_mid", 2, 1, 7, 100, -1, 5);
    @(negedge clk);
    rst = 1'b1;
    dat_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (dat_rdy !== 1'b0 || out_valid !== 1'b0 || out_pd !== 87'd0 || done !== 1'b0 || stall_cnt !== 32'd0) begin
        errors++;
        $display("FAIL rst_mid out%0d: got rdy=%b vld=%b pd=%h done=%b stall=%0d want all 0",
                 i, dat_rdy, out_valid, out_pd, done, stall_cnt);
      end
      rst = 1'b0;
      op_en = 1'b0;
    end
    dat_vld = 1'b0;
    run_layer("after_rst", 2, 1, 7, 100, -1, 0);
  endtask

  initial begin
    test_reset();
    test_min_cube();
    test_basic();
    test_c5();
    test_random_ready();
    test_op_en_ignored();
    test_reset_mid_layer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
